moxie_wb_arbiter: RTL and testbench

//  Two-master Wishbone classic arbiter sharing the single external bus between
//  the fetch (I) and execute (D) ports of the mox125 core. Registered grant,

---
 rtl/moxie_wb_arb_pkg.sv | 28 ++
 rtl/moxie_wb_arb_watchdog.sv | 38 +++
 rtl/moxie_wb_arbiter.sv | 164 ++++++++++++++++
 tb/tb_moxie_wb_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/moxie_wb_arb_pkg.sv
// Shared state encodings and grant helper for the mox125 Wishbone arbiter.
package moxie_wb_arb_pkg;

  typedef logic [1:0] arb_state_t;

  // Arbiter states; the encoding doubles as the registered {D,I} grant vector
  localparam logic [1:0] ARB_IDLE  = 2'b00;
  localparam logic [1:0] ARB_GNT_I = 2'b01;
  localparam logic [1:0] ARB_GNT_D = 2'b10;

  // Winner of an arbitration round taken from IDLE. D has priority unless the
  // fairness counter says I has been passed over often enough.
  function automatic arb_state_t arb_pick(input logic i_req,
                                          input logic d_req,
                                          input logic fair_due);
    arb_state_t pick;
    pick = ARB_IDLE;
    if (i_req && d_req) begin
      pick = fair_due ? ARB_GNT_I : ARB_GNT_D;
    end else if (d_req) begin
      pick = ARB_GNT_D;
    end else if (i_req) begin
      pick = ARB_GNT_I;
    end
    return pick;
  endfunction

endpackage

// File: rtl/moxie_wb_arb_watchdog.sv
// Bus watchdog for the mox125 arbiter: counts stalled strobe cycles of the
// granted master and flags a one-cycle timeout when the limit is reached.
// Only instanced when MOXIE_WB_ARB_TIMEOUT_EN is defined.
module moxie_wb_arb_watchdog #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic granted,
  input  logic stb,
  input  logic ack,
  input  logic err,
  output logic timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             stalled;

  assign stalled = granted & stb & ~ack & ~err;

  // The cycle that would complete TIMEOUT_CYC stalled cycles is the one that errors
  assign timeout = stalled & (cnt_q == CNT_LAST);

  // Stall counter; any completion, the timeout itself, or leaving the grant restarts it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (!granted || ack || err || timeout) begin
      cnt_q <= '0;
    end else if (stb) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/moxie_wb_arbiter.sv
// Two-master Wishbone classic arbiter between the mox125 fetch (I) and
// execute (D) ports and the external wb_* pins. Registered grant held for a
// whole cyc, D priority with an anti-starvation limit for I.
// Optional watchdog enabled by defining MOXIE_WB_ARB_TIMEOUT_EN.
module moxie_wb_arbiter
  import moxie_wb_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 16,
  parameter int SEL_W       = 2,
  parameter int FAIR_LIMIT  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] i_adr_i,
  input  logic              i_cyc_i,
  input  logic              i_stb_i,
  output logic [DATA_W-1:0] i_dat_o,
  output logic              i_ack_o,
  output logic              i_err_o,
  input  logic [ADDR_W-1:0] d_adr_i,
  input  logic [DATA_W-1:0] d_dat_i,
  input  logic [SEL_W-1:0]  d_sel_i,
  input  logic              d_we_i,
  input  logic              d_cyc_i,
  input  logic              d_stb_i,
  output logic [DATA_W-1:0] d_dat_o,
  output logic              d_ack_o,
  output logic              d_err_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic [SEL_W-1:0]  wb_sel_o,
  output logic              wb_we_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  output logic [1:0]        gnt_o
);

  localparam int FAIR_W = $clog2(FAIR_LIMIT + 1);
  localparam logic [FAIR_W-1:0] FAIR_MAX = FAIR_W'(FAIR_LIMIT);

  if (FAIR_LIMIT < 1) begin : g_bad_fair_limit
    $error("moxie_wb_arbiter: FAIR_LIMIT must be at least 1");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("moxie_wb_arbiter: TIMEOUT_CYC must be at least 2");
  end

  arb_state_t        state_q, state_d;
  logic [FAIR_W-1:0] fair_q, fair_d;
  logic              timeout;

  // Next grant and fairness count; arbitration only happens from IDLE so a
  // tenure always ends with one idle turnaround cycle
  always_comb begin
    state_d = state_q;
    fair_d  = fair_q;
    case (state_q)
      ARB_IDLE: begin
        state_d = arb_pick(i_cyc_i, d_cyc_i, fair_q == FAIR_MAX);
        if (state_d == ARB_GNT_I) begin
          fair_d = '0;
        end else if (state_d == ARB_GNT_D) begin
          if (!i_cyc_i) begin
            fair_d = '0;
          end else if (fair_q != FAIR_MAX) begin
            fair_d = fair_q + FAIR_W'(1);
          end
        end
      end
      ARB_GNT_I: begin
        if (!i_cyc_i) begin
          state_d = ARB_IDLE;
        end
      end
      ARB_GNT_D: begin
        if (!d_cyc_i) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Grant and fairness registers; async reset drops the bus mid-tenure
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      fair_q  <= '0;
    end else begin
      state_q <= state_d;
      fair_q  <= fair_d;
    end
  end

`ifdef MOXIE_WB_ARB_TIMEOUT_EN
  logic master_stb;

  assign master_stb = (state_q == ARB_GNT_I) ? i_stb_i :
                      (state_q == ARB_GNT_D) ? d_stb_i : 1'b0;

  moxie_wb_arb_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .granted (state_q != ARB_IDLE),
    .stb     (master_stb),
    .ack     (wb_ack_i),
    .err     (wb_err_i),
    .timeout (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Bus mux and response routing; the non-granted master never sees ack/err,
  // and an I tenure is always a full-width read
  always_comb begin
    wb_adr_o = '0;
    wb_dat_o = '0;
    wb_sel_o = '0;
    wb_we_o  = 1'b0;
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    i_ack_o  = 1'b0;
    i_err_o  = 1'b0;
    d_ack_o  = 1'b0;
    d_err_o  = 1'b0;
    case (state_q)
      ARB_GNT_I: begin
        wb_adr_o = i_adr_i;
        wb_sel_o = '1;
        wb_cyc_o = i_cyc_i;
        wb_stb_o = i_stb_i & ~timeout;
        i_ack_o  = wb_ack_i;
        i_err_o  = wb_err_i | timeout;
      end
      ARB_GNT_D: begin
        wb_adr_o = d_adr_i;
        wb_dat_o = d_dat_i;
        wb_sel_o = d_sel_i;
        wb_we_o  = d_we_i;
        wb_cyc_o = d_cyc_i;
        wb_stb_o = d_stb_i & ~timeout;
        d_ack_o  = wb_ack_i;
        d_err_o  = wb_err_i | timeout;
      end
      default: begin
      end
    endcase
  end

  assign i_dat_o = wb_dat_i;
  assign d_dat_o = wb_dat_i;
  assign gnt_o   = state_q;

endmodule

// File: tb/tb_moxie_wb_arbiter.sv
// Self-checking bench for moxie_wb_arbiter: directed scenarios plus a
// randomized run against a transaction-level model of the arbitration rules.
// Define MOXIE_WB_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_moxie_wb_arbiter;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 16;
  localparam int SEL_W       = 2;
  localparam int FAIR_LIMIT  = 4;
  localparam int TIMEOUT_CYC = 8;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [ADDR_W-1:0] i_adr_i = '0;
  logic              i_cyc_i = 1'b0;
  logic              i_stb_i = 1'b0;
  logic [DATA_W-1:0] i_dat_o;
  logic              i_ack_o;
  logic              i_err_o;
  logic [ADDR_W-1:0] d_adr_i = '0;
  logic [DATA_W-1:0] d_dat_i = '0;
  logic [SEL_W-1:0]  d_sel_i = '0;
  logic              d_we_i = 1'b0;
  logic              d_cyc_i = 1'b0;
  logic              d_stb_i = 1'b0;
  logic [DATA_W-1:0] d_dat_o;
  logic              d_ack_o;
  logic              d_err_o;
  logic [ADDR_W-1:0] wb_adr_o;
  logic [DATA_W-1:0] wb_dat_o;
  logic [SEL_W-1:0]  wb_sel_o;
  logic              wb_we_o;
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic [DATA_W-1:0] wb_dat_i = '0;
  logic              wb_ack_i = 1'b0;
  logic              wb_err_i = 1'b0;
  logic [1:0]        gnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  moxie_wb_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .SEL_W       (SEL_W),
    .FAIR_LIMIT  (FAIR_LIMIT),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_adr_i  (i_adr_i),
    .i_cyc_i  (i_cyc_i),
    .i_stb_i  (i_stb_i),
    .i_dat_o  (i_dat_o),
    .i_ack_o  (i_ack_o),
    .i_err_o  (i_err_o),
    .d_adr_i  (d_adr_i),
    .d_dat_i  (d_dat_i),
    .d_sel_i  (d_sel_i),
    .d_we_i   (d_we_i),
    .d_cyc_i  (d_cyc_i),
    .d_stb_i  (d_stb_i),
    .d_dat_o  (d_dat_o),
    .d_ack_o  (d_ack_o),
    .d_err_o  (d_err_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_sel_o (wb_sel_o),
    .wb_we_o  (wb_we_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i),
    .gnt_o    (gnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Clear all master and slave inputs
  task automatic clear_inputs();
    i_adr_i  = '0; i_cyc_i = 1'b0; i_stb_i = 1'b0;
    d_adr_i  = '0; d_dat_i = '0; d_sel_i = '0; d_we_i = 1'b0;
    d_cyc_i  = 1'b0; d_stb_i = 1'b0;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
  endtask

  // One-cycle reset pulse; inputs change on the falling edge only
  task automatic do_reset();
    @(negedge clk_i);
    clear_inputs();
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Outputs while held in reset, with slave responses driven to prove they are not routed
  task automatic test_reset();
    clear_inputs();
    wb_ack_i = 1'b1;
    wb_err_i = 1'b1;
    wb_dat_i = 16'hC0DE;
    i_cyc_i  = 1'b1;
    d_cyc_i  = 1'b1;
    #3;
    n_checks++;
    if (gnt_o !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_gnt: got %b expected 00", gnt_o); end
    n_checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_bus_ctl: got %b expected 000", {wb_cyc_o, wb_stb_o, wb_we_o}); end
    n_checks++;
    if ({wb_adr_o, wb_dat_o, wb_sel_o} !== '0) begin n_fail++; $display("[TB] FAIL reset_bus_data: got %h expected 0", {wb_adr_o, wb_dat_o, wb_sel_o}); end
    n_checks++;
    if ({i_ack_o, i_err_o, d_ack_o, d_err_o} !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_resp: got %b expected 0000", {i_ack_o, i_err_o, d_ack_o, d_err_o}); end
    n_checks++;
    if (i_dat_o !== 16'hC0DE || d_dat_o !== 16'hC0DE) begin n_fail++; $display("[TB] FAIL reset_dat_broadcast: got %h/%h expected c0de", i_dat_o, d_dat_o); end
    do_reset();
  endtask

  // Lone I request: one cycle latency, forced read attributes, ack with cyc drop
  task automatic test_i_only();
    do_reset();
    @(negedge clk_i);
    i_cyc_i = 1'b1; i_stb_i = 1'b1; i_adr_i = 32'h1234_5678;
    d_adr_i = 32'hDEAD_BEEF; d_we_i = 1'b1; d_sel_i = 2'b01; d_dat_i = 16'hA5A5;
    #1;
    n_checks++;
    if (gnt_o !== 2'b00 || wb_cyc_o !== 1'b0) begin n_fail++; $display("[TB] FAIL i_only_latency: gnt %b cyc %b expected 00/0", gnt_o, wb_cyc_o); end
    @(negedge clk_i);
    #1;
    n_checks++;
    if (gnt_o !== 2'b01) begin n_fail++; $display("[TB] FAIL i_only_gnt: got %b expected 01", gnt_o); end
    n_checks++;
    if (wb_adr_o !== 32'h1234_5678) begin n_fail++; $display("[TB] FAIL i_only_adr: got %h expected 12345678", wb_adr_o); end
    n_checks++;
    if ({wb_we_o, wb_sel_o, wb_dat_o} !== {1'b0, 2'b11, 16'h0000}) begin n_fail++; $display("[TB] FAIL i_only_attr: we %b sel %b dat %h expected 0/11/0000", wb_we_o, wb_sel_o, wb_dat_o); end
    n_checks++;
    if ({wb_cyc_o, wb_stb_o} !== 2'b11) begin n_fail++; $display("[TB] FAIL i_only_cycstb: got %b expected 11", {wb_cyc_o, wb_stb_o}); end
    wb_ack_i = 1'b1; wb_dat_i = 16'h5AC3;
    #1;
    n_checks++;
    if ({i_ack_o, d_ack_o} !== 2'b10) begin n_fail++; $display("[TB] FAIL i_only_ack_route: got %b expected 10", {i_ack_o, d_ack_o}); end
    n_checks++;
    if (i_dat_o !== 16'h5AC3 || d_dat_o !== 16'h5AC3) begin n_fail++; $display("[TB] FAIL i_only_dat: got %h/%h expected 5ac3", i_dat_o, d_dat_o); end
    @(negedge clk_i);
    i_cyc_i = 1'b0; i_stb_i = 1'b0;
    #1;
    n_checks++;
    if (i_ack_o !== 1'b1 || gnt_o !== 2'b01) begin n_fail++; $display("[TB] FAIL i_only_ack_with_drop: ack %b gnt %b expected 1/01", i_ack_o, gnt_o); end
    @(negedge clk_i);
    wb_ack_i = 1'b0;
    #1;
    n_checks++;
    if (gnt_o !== 2'b00) begin n_fail++; $display("[TB] FAIL i_only_release: got %b expected 00", gnt_o); end
  endtask

  // Simultaneous requests with no history go to D; three beats keep the grant
  task automatic test_contested();
    do_reset();
    @(negedge clk_i);
    i_cyc_i = 1'b1; i_stb_i = 1'b1; i_adr_i = 32'h0000_0100;
    d_cyc_i = 1'b1; d_stb_i = 1'b1; d_adr_i = 32'h8000_0040;
    d_we_i = 1'b1; d_sel_i = 2'b10; d_dat_i = 16'hBEEF;
    @(negedge clk_i);
    #1;
    n_checks++;
    if (gnt_o !== 2'b10) begin n_fail++; $display("[TB] FAIL contested_gnt: got %b expected 10", gnt_o); end
    n_checks++;
    if ({wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o} !== {32'h8000_0040, 16'hBEEF, 2'b10, 1'b1}) begin
      n_fail++; $display("[TB] FAIL contested_d_bus: got %h %h %b %b expected 80000040 beef 10 1", wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o);
    end
    for (int beat = 0; beat < 3; beat++) begin
      wb_ack_i = 1'b1;
      #1;
      n_checks++;
      if ({gnt_o, d_ack_o, i_ack_o} !== 4'b1010) begin n_fail++; $display("[TB] FAIL d_burst_beat%0d: gnt %b dack %b iack %b expected 10/1/0", beat, gnt_o, d_ack_o, i_ack_o); end
      @(negedge clk_i);
      wb_ack_i = 1'b0; d_stb_i = 1'b0;
      #1;
      n_checks++;
      if ({gnt_o, wb_stb_o, i_ack_o} !== 4'b1000) begin n_fail++; $display("[TB] FAIL d_burst_gap%0d: gnt %b stb %b iack %b expected 10/0/0", beat, gnt_o, wb_stb_o, i_ack_o); end
      @(negedge clk_i);
      d_stb_i = 1'b1;
    end
    wb_err_i = 1'b1;
    #1;
    n_checks++;
    if ({d_err_o, i_err_o} !== 2'b10) begin n_fail++; $display("[TB] FAIL d_err_route: got %b expected 10", {d_err_o, i_err_o}); end
    @(negedge clk_i);
    clear_inputs();
  endtask

  // D drops cyc with I waiting: one idle turnaround cycle, then I
  task automatic test_back_to_back();
    do_reset();
    @(negedge clk_i);
    i_cyc_i = 1'b1; i_stb_i = 1'b1; i_adr_i = 32'h0000_2000;
    d_cyc_i = 1'b1; d_stb_i = 1'b1; d_adr_i = 32'h0000_3000;
    @(negedge clk_i);
    d_cyc_i = 1'b0; d_stb_i = 1'b0;
    #1;
    n_checks++;
    if ({gnt_o, wb_cyc_o} !== 3'b100) begin n_fail++; $display("[TB] FAIL b2b_drop: gnt %b cyc %b expected 10/0", gnt_o, wb_cyc_o); end
    @(negedge clk_i);
    #1;
    n_checks++;
    if ({gnt_o, wb_cyc_o} !== 3'b000) begin n_fail++; $display("[TB] FAIL b2b_idle: gnt %b cyc %b expected 00/0", gnt_o, wb_cyc_o); end
    @(negedge clk_i);
    #1;
    n_checks++;
    if (gnt_o !== 2'b01 || wb_adr_o !== 32'h0000_2000) begin n_fail++; $display("[TB] FAIL b2b_i_next: gnt %b adr %h expected 01/00002000", gnt_o, wb_adr_o); end
    @(negedge clk_i);
    clear_inputs();
  endtask

  // Both masters keep requesting: D wins FAIR_LIMIT contested rounds, then I once, then D again
  task automatic test_fairness();
    logic [1:0] want;
    do_reset();
    for (int r = 0; r <= FAIR_LIMIT + 1; r++) begin
      @(negedge clk_i);
      i_cyc_i = 1'b1; d_cyc_i = 1'b1;
      @(negedge clk_i);
      #1;
      want = (r == FAIR_LIMIT) ? 2'b01 : 2'b10;
      n_checks++;
      if (gnt_o !== want) begin n_fail++; $display("[TB] FAIL fairness_round%0d: got %b expected %b", r, gnt_o, want); end
      i_cyc_i = 1'b0; d_cyc_i = 1'b0;
    end
    @(negedge clk_i);
    clear_inputs();
  endtask

`ifdef MOXIE_WB_ARB_TIMEOUT_EN
  // D strobes with no slave answer: err pulses once on the TIMEOUT_CYC-th stalled cycle
  task automatic test_timeout();
    logic want_err;
    do_reset();
    @(negedge clk_i);
    d_cyc_i = 1'b1; d_stb_i = 1'b1; d_adr_i = 32'h0000_0F00;
    for (int k = 1; k <= TIMEOUT_CYC + 1; k++) begin
      @(negedge clk_i);
      #1;
      want_err = (k == TIMEOUT_CYC);
      n_checks++;
      if ({d_err_o, wb_stb_o, i_err_o} !== {want_err, ~want_err, 1'b0}) begin
        n_fail++; $display("[TB] FAIL timeout_cycle%0d: derr %b stb %b ierr %b expected %b/%b/0", k, d_err_o, wb_stb_o, i_err_o, want_err, ~want_err);
      end
    end
    @(negedge clk_i);
    clear_inputs();
  endtask
`endif

  // Reset asserted between clock edges in the middle of a D tenure
  task automatic test_async_reset();
    do_reset();
    @(negedge clk_i);
    d_cyc_i = 1'b1; d_stb_i = 1'b1;
    @(negedge clk_i);
    #1;
    n_checks++;
    if (gnt_o !== 2'b10) begin n_fail++; $display("[TB] FAIL async_rst_pre: got %b expected 10", gnt_o); end
    #2;
    rst_i = 1'b1;
    #1;
    n_checks++;
    if ({gnt_o, wb_cyc_o, wb_stb_o} !== 4'b0000) begin n_fail++; $display("[TB] FAIL async_rst_drop: gnt %b cyc %b stb %b expected 00/0/0", gnt_o, wb_cyc_o, wb_stb_o); end
    @(negedge clk_i);
    clear_inputs();
    rst_i = 1'b0;
  endtask

  // Random masters and slave against a transaction-level model of who owns the bus
  task automatic test_random(input int n_cycles);
    int owner;
    int fair;
    int stall;
    logic mstb, to;
    logic [52:0] exp_bus, act_bus;
    logic [17:0] exp_i, exp_d;
    logic [1:0]  exp_gnt;
    do_reset();
    owner = 0;
    fair  = 0;
    stall = 0;
    for (int c = 0; c < n_cycles; c++) begin
      @(negedge clk_i);
      if ($urandom_range(0, 3) == 0) i_cyc_i = ~i_cyc_i;
      if ($urandom_range(0, 3) == 0) d_cyc_i = ~d_cyc_i;
      i_stb_i  = i_cyc_i & 1'($urandom_range(0, 1));
      d_stb_i  = d_cyc_i & 1'($urandom_range(0, 1));
      i_adr_i  = $urandom;
      d_adr_i  = $urandom;
      d_dat_i  = 16'($urandom);
      d_sel_i  = 2'($urandom);
      d_we_i   = 1'($urandom_range(0, 1));
      wb_dat_i = 16'($urandom);
      wb_ack_i = ($urandom_range(0, 3) == 0);
      wb_err_i = ($urandom_range(0, 15) == 0);
      #1;
      mstb = (owner == 1) ? i_stb_i : (owner == 2) ? d_stb_i : 1'b0;
`ifdef MOXIE_WB_ARB_TIMEOUT_EN
      to = (owner != 0) && mstb && !wb_ack_i && !wb_err_i && (stall == TIMEOUT_CYC - 1);
`else
      to = 1'b0;
`endif
      exp_gnt = 2'b00;
      exp_bus = '0;
      exp_i   = {2'b00, wb_dat_i};
      exp_d   = {2'b00, wb_dat_i};
      if (owner == 1) begin
        exp_gnt = 2'b01;
        exp_bus = {i_adr_i, 16'h0000, 2'b11, 1'b0, i_cyc_i, i_stb_i & ~to};
        exp_i   = {wb_ack_i, wb_err_i | to, wb_dat_i};
      end else if (owner == 2) begin
        exp_gnt = 2'b10;
        exp_bus = {d_adr_i, d_dat_i, d_sel_i, d_we_i, d_cyc_i, d_stb_i & ~to};
        exp_d   = {wb_ack_i, wb_err_i | to, wb_dat_i};
      end
      act_bus = {wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o};
      n_checks++;
      if (gnt_o !== exp_gnt) begin n_fail++; $display("[TB] FAIL rand_gnt c%0d: got %b expected %b", c, gnt_o, exp_gnt); end
      n_checks++;
      if (act_bus !== exp_bus) begin n_fail++; $display("[TB] FAIL rand_bus c%0d: got %h expected %h", c, act_bus, exp_bus); end
      n_checks++;
      if ({i_ack_o, i_err_o, i_dat_o} !== exp_i) begin n_fail++; $display("[TB] FAIL rand_i c%0d: got %h expected %h", c, {i_ack_o, i_err_o, i_dat_o}, exp_i); end
      n_checks++;
      if ({d_ack_o, d_err_o, d_dat_o} !== exp_d) begin n_fail++; $display("[TB] FAIL rand_d c%0d: got %h expected %h", c, {d_ack_o, d_err_o, d_dat_o}, exp_d); end
      // advance the model to the state after the coming clock edge
      if (owner == 0 || wb_ack_i || wb_err_i || to) stall = 0;
      else if (mstb) stall = stall + 1;
      if (owner == 0) begin
        if (i_cyc_i && d_cyc_i) begin
          if (fair == FAIR_LIMIT) begin
            owner = 1; fair = 0;
          end else begin
            owner = 2; fair = (fair + 1 > FAIR_LIMIT) ? FAIR_LIMIT : fair + 1;
          end
        end else if (d_cyc_i) begin
          owner = 2; fair = 0;
        end else if (i_cyc_i) begin
          owner = 1; fair = 0;
        end
      end else if (owner == 1 && !i_cyc_i) begin
        owner = 0;
      end else if (owner == 2 && !d_cyc_i) begin
        owner = 0;
      end
    end
    @(negedge clk_i);
    clear_inputs();
  endtask

  // Runaway guard so the bench always ends
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation ran past its time budget");
    $fatal(1, "[TB] simulation time budget exceeded");
  end

  // Test sequence
  initial begin
    test_reset();
    test_i_only();
    test_contested();
    test_back_to_back();
    test_fairness();
`ifdef MOXIE_WB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_async_reset();
    test_random(600);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
